// File: rtl/qws_pkg.sv
// Shared types, constants and fold/reconstruct helpers for quarter_wave_sequencer.
// SIGNED_OUT_EN selects two's-complement output instead of offset binary.
package qws_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int ROM_AW       = 7;
    localparam int ROM_DW       = 9;
    localparam int SAMPLE_W     = 10;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 10'd512;
    localparam int DRAIN_CYCLES = 2;

`ifdef SIGNED_OUT_EN
    localparam logic [SAMPLE_W-1:0] SAMPLE_RST = 10'd0;
`else
    localparam logic [SAMPLE_W-1:0] SAMPLE_RST = MIDSCALE;
`endif

    // Odd quadrants walk the quarter table backwards.
    function automatic logic [ROM_AW-1:0] fold_addr(input logic mirror, input logic [ROM_AW-1:0] idx);
        if (mirror) begin
            fold_addr = 7'd127 - idx;
        end else begin
            fold_addr = idx;
        end
    endfunction

    function automatic logic [SAMPLE_W-1:0] recon(input logic neg, input logic [ROM_DW-1:0] d);
`ifdef SIGNED_OUT_EN
        if (neg) begin
            recon = ~{1'b0, d};
        end else begin
            recon = {1'b0, d};
        end
`else
        if (neg) begin
            recon = 10'd511 - {1'b0, d};
        end else begin
            recon = MIDSCALE + {1'b0, d};
        end
`endif
    endfunction

endpackage

// File: rtl/qws_tick_div.sv
// Sample-tick divider: tick is high in the cycle where the count reaches DIV-1.
module qws_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count and tick decode.
    always_comb begin
        cnt_d = cnt_q;
        tick  = en && (cnt_q == LAST);
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/quarter_wave_sequencer.sv
// Rebuilds a 512-point 10-bit sine stream from a 128x9 quarter-wave memory.
// Define SIGNED_OUT_EN for two's-complement samples (default: offset binary).
module quarter_wave_sequencer
    import qws_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int DIV     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PHASE_W-1:0]  freq_word,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [ROM_DW-1:0]   rom_data,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                busy
);
    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PHASE_W-1:0]  fw_q, fw_d;
    logic                stop_pend_q, stop_pend_d;
    logic [1:0]          drain_cnt_q, drain_cnt_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [1:0]          sign_q, sign_d;
    logic [1:0]          vld_q, vld_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                busy_q, busy_d;

    logic                tick_s;
    logic [1:0]          quad_s;
    logic [ROM_AW-1:0]   idx_s;
    logic [PHASE_W-1:0]  sum_s;
    logic                carry_s;

    qws_tick_div #(.DIV(DIV)) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != RUN),
        .en   (state_q == RUN),
        .tick (tick_s)
    );

    // Next-state, accumulator, fold and alignment pipeline.
    always_comb begin
        quad_s           = phase_q[PHASE_W-1 -: 2];
        idx_s            = phase_q[PHASE_W-3 -: ROM_AW];
        {carry_s, sum_s} = {1'b0, phase_q} + {1'b0, fw_q};

        state_d        = state_q;
        phase_d        = phase_q;
        fw_d           = fw_q;
        stop_pend_d    = stop_pend_q;
        drain_cnt_d    = drain_cnt_q;
        rom_addr_d     = rom_addr_q;
        sign_d         = {sign_q[0], 1'b0};
        vld_d          = {vld_q[0], 1'b0};
        sample_valid_d = vld_q[1];
        if (vld_q[1]) begin
            sample_d = recon(sign_q[1], rom_data);
        end else begin
            sample_d = sample_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    phase_d     = '0;
                    fw_d        = freq_word;
                    stop_pend_d = 1'b0;
                    state_d     = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
                if (tick_s) begin
                    rom_addr_d = fold_addr(quad_s[0], idx_s);
                    vld_d[0]   = 1'b1;
                    sign_d[0]  = quad_s[1];
                    // A zero step never wraps, so it must be allowed to stop directly.
                    if (stop_pend_q && (carry_s || (fw_q == '0))) begin
                        phase_d     = '0;
                        stop_pend_d = 1'b0;
                        drain_cnt_d = 2'd0;
                        state_d     = DRAIN;
                    end else begin
                        phase_d = sum_s;
                        if (carry_s) begin
                            fw_d = freq_word;
                        end else begin
                            fw_d = fw_q;
                        end
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            fw_q           <= '0;
            stop_pend_q    <= 1'b0;
            drain_cnt_q    <= 2'd0;
            rom_addr_q     <= 7'd0;
            sign_q         <= 2'b00;
            vld_q          <= 2'b00;
            sample_q       <= SAMPLE_RST;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            fw_q           <= fw_d;
            stop_pend_q    <= stop_pend_d;
            drain_cnt_q    <= drain_cnt_d;
            rom_addr_q     <= rom_addr_d;
            sign_q         <= sign_d;
            vld_q          <= vld_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_quarter_wave_sequencer.sv
// Directed bench for quarter_wave_sequencer: DIV=1 and DIV=4 instances, each with its own ROM model.
module tb_quarter_wave_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, stop1 = 1'b0, start4 = 1'b0, stop4 = 1'b0;
    logic [15:0] fw1 = 16'd128, fw4 = 16'd128;
    logic [6:0]  rom_addr1, rom_addr4;
    logic [8:0]  rom_data1 = 9'd0, rom_data4 = 9'd0;
    logic [9:0]  sample1, sample4;
    logic        sv1, sv4, busy1, busy4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    quarter_wave_sequencer #(.PHASE_W(16), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1), .freq_word(fw1),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .sample(sample1),
        .sample_valid(sv1), .busy(busy1)
    );

    quarter_wave_sequencer #(.PHASE_W(16), .DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .stop(stop4), .freq_word(fw4),
        .rom_addr(rom_addr4), .rom_data(rom_data4), .sample(sample4),
        .sample_valid(sv4), .busy(busy4)
    );

    // Quarter-table contents: monotonic, reaches 511 at index 127.
    function automatic logic [8:0] q_of(input logic [6:0] a);
        q_of = {a, 2'b00} + {7'd0, a[6:5]};
    endfunction

    function automatic logic [6:0] addr_of(input logic [15:0] ph);
        logic [6:0] idx;
        idx = ph[13:7];
        addr_of = ph[14] ? (7'd127 - idx) : idx;
    endfunction

    function automatic logic [9:0] smp_of(input logic [15:0] ph);
        logic [8:0] d;
        d = q_of(addr_of(ph));
        smp_of = ph[15] ? (10'd511 - {1'b0, d}) : (10'd512 + {1'b0, d});
    endfunction

    always @(posedge clk) begin
        rom_data1 <= q_of(rom_addr1);
        rom_data4 <= q_of(rom_addr4);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          strobes;
        logic [15:0] ph4;
        logic [15:0] fwm;
        logic [15:0] phq[$];
        logic [16:0] nxt;

        // Reset values
        step();
        step();
        check_eq("rst_addr", 32'(rom_addr1), 32'd0);
        check_eq("rst_sample", 32'(sample1), 32'd512);
        check_eq("rst_valid", 32'(sv1), 32'd0);
        check_eq("rst_busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        step();

        // Full sweep at DIV=1 with a mid-cycle stop in the second cycle
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check_eq("busy_rise", 32'(busy1), 32'd1);
        strobes = 0;
        for (int c = 1; c <= 1030; c++) begin
            step();
            check_eq("sw_addr", 32'(rom_addr1),
                     (c <= 1024) ? 32'(addr_of(16'((c - 1) * 128))) : 32'd0);
            check_eq("sw_valid", 32'(sv1), (c >= 3 && c <= 1026) ? 32'd1 : 32'd0);
            check_eq("sw_busy", 32'(busy1), (c <= 1025) ? 32'd1 : 32'd0);
            if (c >= 3 && c <= 1026) begin
                check_eq("sw_sample", 32'(sample1), 32'(smp_of(16'((c - 3) * 128))));
            end else if (c > 1026) begin
                check_eq("sw_hold", 32'(sample1), 32'd511);
            end
            if (sv1) strobes++;
            stop1 = (c == 600);
        end
        check_eq("sw_strobes", 32'(strobes), 32'd1024);

        // Start+stop together in IDLE runs; start while running is ignored; zero step stops on next tick
        start1 = 1'b1;
        stop1  = 1'b1;
        step();
        start1 = 1'b0;
        stop1  = 1'b0;
        fw1    = 16'd0;
        for (int c = 1; c <= 540; c++) begin
            step();
            check_eq("col_addr", 32'(rom_addr1),
                     (c <= 512) ? 32'(addr_of(16'((c - 1) * 128))) : 32'd0);
            check_eq("col_busy", 32'(busy1), (c <= 533) ? 32'd1 : 32'd0);
            check_eq("col_valid", 32'(sv1), (c >= 3 && c <= 534) ? 32'd1 : 32'd0);
            start1 = (c == 299);
            stop1  = (c == 530);
        end

        // DIV=4 spacing and frequency change taking effect at the wrap
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        ph4 = 16'd0;
        fwm = 16'd128;
        for (int c = 1; c <= 2100; c++) begin
            step();
            if (c % 4 == 0) begin
                check_eq("d4_addr", 32'(rom_addr4), 32'(addr_of(ph4)));
                phq.push_back(ph4);
                nxt = {1'b0, ph4} + {1'b0, fwm};
                ph4 = nxt[15:0];
                if (nxt[16]) fwm = fw4;
            end
            if (c >= 6 && c % 4 == 2) begin
                check_eq("d4_valid", 32'(sv4), 32'd1);
                check_eq("d4_sample", 32'(sample4), 32'(smp_of(phq.pop_front())));
            end else begin
                check_eq("d4_gap", 32'(sv4), 32'd0);
            end
            if (c == 10) fw4 = 16'd256;
        end

        // Reset mid-run with a sample still in flight
        rst = 1'b1;
        #1;
        check_eq("mr_addr", 32'(rom_addr4), 32'd0);
        check_eq("mr_sample", 32'(sample4), 32'd512);
        check_eq("mr_valid", 32'(sv4), 32'd0);
        check_eq("mr_busy", 32'(busy4), 32'd0);
        step();
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            check_eq("mr_quiet", 32'(sv4), 32'd0);
            check_eq("mr_idle", 32'(busy4), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/quarter_wave_sequencer.md
# quarter_wave_sequencer

Sequencer that drives the 128-entry, 9-bit quarter-cycle sine memory and rebuilds a full 512-point-per-cycle, 10-bit sine stream from it. A phase accumulator advances on a programmable sample tick. The top phase bits are folded into a mirrored ROM address plus a sign bit, and the ROM's registered read is realigned with that sign. The block sits between the memory and the DAC/PWM output stage and owns start/stop sequencing, including a clean stop at the cycle boundary.

## Interface
Parameters:
- PHASE_W, 16: phase accumulator width; must be ≥ 9.
- DIV, 4: clock cycles per sample tick; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that starts generation from phase 0.
- stop  in  1  single-cycle pulse that requests a stop at the next full-cycle wrap.
- freq_word  in  PHASE_W  phase increment per tick.
- rom_addr  out  7  registered address to the quarter-wave memory.
- rom_data  in  9  memory read data; valid one cycle after rom_addr.
- sample  out  10  reconstructed sample.
- sample_valid  out  1  one-cycle strobe when sample updates.
- busy  out  1  high in RUN and DRAIN.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - A start pulse loads phase = 0, latches freq_word into fw_q, clears the tick divider, and moves to RUN.
  - stop is ignored in IDLE. If start and stop arrive in the same cycle, the stop is dropped.
- RUN:
  - Tick fires when the divider reaches DIV-1. The divider then returns to 0.
  - On each tick: quad = phase[PHASE_W-1:PHASE_W-2] and idx = phase[PHASE_W-3 -: 7].
  - rom_addr <= quad[0] ? 127-idx : idx.
  - phase <= phase + fw_q, modulo 2^PHASE_W.
  - Carry out of that add is a wrap. On a wrap, fw_q reloads from freq_word.
- start while busy is ignored.
- A stop pulse in RUN sets stop_pend. stop_pend only ever takes effect on a tick:
  - On a tick with stop_pend set and a wrap (or with fw_q == 0): issue the address for the current phase, force phase to 0, clear stop_pend, go to DRAIN.
- DRAIN:
  - Lasts exactly 2 cycles, long enough to flush the pipeline, then returns to IDLE.
  - No ticks are generated in DRAIN.
- Reconstruction, offset-binary output:
  - When quad[1] = 0: sample = 512 + rom_data.
  - When quad[1] = 1: sample = 511 - rom_data.
  - All arithmetic is 10-bit unsigned. Range is 0..1023 and never overflows.
- The sign bit (quad[1]) and a valid bit travel through a 2-stage shift register so they stay aligned with rom_data.

## Timing
- Reset values:
  - rom_addr = 0, sample = 512 (0 with SIGNED_OUT_EN), sample_valid = 0, busy = 0.
  - phase = 0, fw_q = 0, stop_pend = 0, divider = 0, state = IDLE, pipeline valid bits = 0.
- Tick at edge k:
  - rom_addr updates at edge k.
  - The memory registers it at edge k+1.
  - sample and sample_valid update at edge k+2.
  - Latency is 2 cycles at any DIV, including DIV = 1 (back-to-back ticks, fully pipelined).
- After start is accepted at edge s, the first tick is at edge s+DIV.
- busy rises at the edge after start. It falls 2 cycles after the stopping tick, the same edge the last sample_valid is produced.
- sample holds its last value while idle.
- rst mid-run aborts immediately. Every register returns to its reset value and any in-flight sample_valid is discarded.

## Configuration
- SIGNED_OUT_EN defined: sample is two's complement.
  - rom_data zero-extended when quad[1] = 0.
  - -1 - rom_data when quad[1] = 1.
  - Reset and idle value is 0.
- SIGNED_OUT_EN undefined: offset-binary behaviour as described in Operation.

## Structure
- Package qws_pkg holds:
  - State enum: IDLE, RUN, DRAIN.
  - Constants: ROM_AW = 7, ROM_DW = 9, SAMPLE_W = 10, MIDSCALE = 512, DRAIN_CYCLES = 2.
- One sub-module, qws_tick_div: DIV counter with synchronous clear and a single-cycle tick output.
- The FSM, accumulator, fold logic and alignment pipeline stay in the top module.

## Test plan
- Reset mid-stream: assert rst while RUN with sample_valid pending. Required: all outputs go to reset values at once, and no further strobes appear.
- Full-cycle sweep: DIV = 1, PHASE_W = 16, freq_word = 128 (one address step per tick), start. Required:
  - rom_addr runs 0..127, then 127..0, then 0..127, then 127..0.
  - With a ROM model, 512 sample_valid strobes trace 512+q, 512+q, 511-q, 511-q, with sample_valid 2 cycles after each address.
- Divider spacing: DIV = 4, freq_word = 128. Required: sample_valid strobes exactly 4 cycles apart, and the first at edge s+6.
- Clean stop: stop pulsed mid-cycle at freq_word = 128. Required:
  - Generation continues to the wrap.
  - The final issued address is 0 from quadrant 3 mirrored (idx 127 → addr 0).
  - busy falls 2 cycles later. Total strobes is a multiple of 512.
- Start/stop collision and ignores:
  - start and stop in the same cycle in IDLE → runs.
  - start during RUN → no phase reset.
  - freq_word = 0 plus stop → DRAIN on the next tick.
- Frequency change: change freq_word to 256 mid-cycle. Required: the step stays 128 until the wrap, then becomes 256 (addresses 0, 2, 4, ...).
